// File: rtl/eth_app_pkt_gen_if.sv
// Application-side bundle between the packet generator and eth_tx.
// The generator side uses the master modport; eth_tx (or a bench) uses slave.
interface eth_app_pkt_gen_if #(
    parameter int DATA_W    = 16,
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int LEN_W  = $clog2(KEEP_W + 1);

    logic                 app_early_v_o;
    logic                 app_ready_v_i;
    logic                 app_valid_o;
    logic [DATA_W-1:0]    app_data_o;
    logic [LEN_W-1:0]     app_len_o;
    logic [PKT_LEN_W-1:0] app_pkt_len_o;
    logic [UDP_CS_W-1:0]  app_cs_o;
    logic                 app_cancel_o;

    modport master (
        output app_early_v_o, app_valid_o, app_data_o, app_len_o,
               app_pkt_len_o, app_cs_o, app_cancel_o,
        input  app_ready_v_i
    );

    modport slave (
        input  app_early_v_o, app_valid_o, app_data_o, app_len_o,
               app_pkt_len_o, app_cs_o, app_cancel_o,
        output app_ready_v_i
    );
endinterface

// File: rtl/eth_app_pkt_gen.sv
// Application-side packet generator for eth_tx: early-valid/ready-grant
// handshake, then contiguous payload beats with byte p + k*KEEP_W + j.
// Optional cancel injection is compiled in with PKT_GEN_CANCEL_EN.
module eth_app_pkt_gen #(
    parameter int DATA_W    = 16,
    parameter int PKT_LEN_W = 16,
    parameter int UDP_CS_W  = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [PKT_LEN_W-1:0] pkt_len_i,
    input  logic [CNT_W-1:0]     pkt_cnt_i,
    input  logic [7:0]           gap_i,
    input  logic [UDP_CS_W-1:0]  cs_i,
    input  logic [PKT_LEN_W-1:0] cancel_at_i,
    eth_app_pkt_gen_if.master    app,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     sent_cnt_o,
    output logic [CNT_W-1:0]     cancel_cnt_o
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int LEN_W  = $clog2(KEEP_W + 1);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, GAP} state_t;

    state_t               state_q, state_d;
    logic [PKT_LEN_W-1:0] pkt_len_q, pkt_len_d;
    logic [PKT_LEN_W-1:0] cancel_at_q, cancel_at_d;
    logic [PKT_LEN_W-1:0] rem_q, rem_d;      // bytes still to send in this packet
    logic [PKT_LEN_W-1:0] k_q, k_d;          // beat index within the packet
    logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]     p_q, p_d;          // packet index within the burst
    logic [CNT_W-1:0]     sent_q, sent_d;
    logic [CNT_W-1:0]     cancel_cnt_q, cancel_cnt_d;
    logic [7:0]           gap_q, gap_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [7:0]           base_q, base_d;    // byte value of lane 0, mod 256
    logic [UDP_CS_W-1:0]  cs_q, cs_d;
    logic                 done_q, done_d;

    logic                 last_beat;
    logic                 cancel_hit;
    logic                 pkt_end;
    logic [CNT_W-1:0]     p_inc;
    logic [LEN_W-1:0]     beat_len;

`ifdef PKT_GEN_CANCEL_EN
    assign cancel_hit   = (k_q == cancel_at_q);
    assign cancel_cnt_o = cancel_cnt_q;
`else
    logic unused_cancel;
    assign unused_cancel = ^{cancel_at_q, cancel_cnt_q};
    assign cancel_hit    = 1'b0;
    assign cancel_cnt_o  = '0;
`endif

    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign sent_cnt_o        = sent_q;
    assign app.app_pkt_len_o = pkt_len_q;
    assign app.app_cs_o      = cs_q;

    // Next-state, packet bookkeeping and beat outputs.
    always_comb begin
        state_d      = state_q;
        pkt_len_d    = pkt_len_q;
        cancel_at_d  = cancel_at_q;
        rem_d        = rem_q;
        k_d          = k_q;
        pkt_cnt_d    = pkt_cnt_q;
        p_d          = p_q;
        sent_d       = sent_q;
        cancel_cnt_d = cancel_cnt_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        base_d       = base_q;
        cs_d         = cs_q;
        done_d       = 1'b0;
        pkt_end      = 1'b0;
        p_inc        = p_q + CNT_W'(1);

        app.app_early_v_o = 1'b0;
        app.app_valid_o   = 1'b0;
        app.app_cancel_o  = 1'b0;
        app.app_data_o    = '0;
        app.app_len_o     = '0;

        // The remaining-byte count makes the last beat and its length fall out
        // without a divider: the final beat carries 1..KEEP_W bytes.
        last_beat = (rem_q <= PKT_LEN_W'(KEEP_W));
        beat_len  = last_beat ? rem_q[LEN_W-1:0] : LEN_W'(KEEP_W);

        case (state_q)
            IDLE: begin
                if (start_i && (pkt_len_i != '0) && (pkt_cnt_i != '0)) begin
                    pkt_len_d    = pkt_len_i;
                    pkt_cnt_d    = pkt_cnt_i;
                    gap_d        = gap_i;
                    cs_d         = cs_i;
                    cancel_at_d  = cancel_at_i;
                    sent_d       = '0;
                    cancel_cnt_d = '0;
                    p_d          = '0;
                    state_d      = HEAD;
                end
            end
            HEAD: begin
                app.app_early_v_o = 1'b1;
                if (app.app_ready_v_i) begin
                    k_d     = '0;
                    rem_d   = pkt_len_q;
                    base_d  = p_q[7:0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cancel_hit) begin
                    app.app_cancel_o = 1'b1;
                    pkt_end          = 1'b1;
                    cancel_cnt_d     = (cancel_cnt_q == '1) ? cancel_cnt_q
                                                           : cancel_cnt_q + CNT_W'(1);
                end else begin
                    app.app_valid_o = 1'b1;
                    app.app_len_o   = beat_len;
                    for (int j = 0; j < KEEP_W; j++) begin
                        if (LEN_W'(j) < beat_len)
                            app.app_data_o[8*j +: 8] = base_q + 8'(j);
                    end
                    k_d    = k_q + PKT_LEN_W'(1);
                    rem_d  = rem_q - PKT_LEN_W'(KEEP_W);
                    base_d = base_q + 8'(KEEP_W);
                    if (last_beat) begin
                        pkt_end = 1'b1;
                        sent_d  = (sent_q == '1) ? sent_q : sent_q + CNT_W'(1);
                    end
                end
                if (pkt_end) begin
                    p_d = p_inc;
                    if (p_inc == pkt_cnt_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (gap_q != 8'd0) begin
                        gap_cnt_d = gap_q - 8'd1;
                        state_d   = GAP;
                    end else begin
                        state_d = HEAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) state_d = HEAD;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and configuration registers; reset clears every output at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pkt_len_q    <= '0;
            cancel_at_q  <= '0;
            rem_q        <= '0;
            k_q          <= '0;
            pkt_cnt_q    <= '0;
            p_q          <= '0;
            sent_q       <= '0;
            cancel_cnt_q <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            base_q       <= '0;
            cs_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_len_q    <= pkt_len_d;
            cancel_at_q  <= cancel_at_d;
            rem_q        <= rem_d;
            k_q          <= k_d;
            pkt_cnt_q    <= pkt_cnt_d;
            p_q          <= p_d;
            sent_q       <= sent_d;
            cancel_cnt_q <= cancel_cnt_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            base_q       <= base_d;
            cs_q         <= cs_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_eth_app_pkt_gen.sv
// Directed + randomized bench for eth_app_pkt_gen. Expected beats come from a
// per-packet model: B = ceil(len/KEEP_W), byte = (p + k*KEEP_W + j) mod 256.
module tb_eth_app_pkt_gen;
    localparam int DW = 16;
    localparam int KW = DW / 8;
    localparam int LW = $clog2(KW + 1);
`ifdef PKT_GEN_CANCEL_EN
    localparam bit CANC_EN = 1'b1;
`else
    localparam bit CANC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] pkt_len_i = '0;
    logic [15:0] pkt_cnt_i = '0;
    logic [7:0]  gap_i = '0;
    logic [15:0] cs_i = '0;
    logic [15:0] cancel_at_i = '0;
    logic        busy_o, done_o;
    logic [15:0] sent_cnt_o, cancel_cnt_o;

    int errors = 0;
    int checks = 0;

    eth_app_pkt_gen_if #(.DATA_W(DW)) bus ();

    eth_app_pkt_gen #(.DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .pkt_len_i   (pkt_len_i),
        .pkt_cnt_i   (pkt_cnt_i),
        .gap_i       (gap_i),
        .cs_i        (cs_i),
        .cancel_at_i (cancel_at_i),
        .app         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sent_cnt_o  (sent_cnt_o),
        .cancel_cnt_o(cancel_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int p, input int k, input int blen);
        logic [DW-1:0] d;
        d = '0;
        for (int j = 0; j < KW; j++)
            if (j < blen) d[8*j +: 8] = 8'((p + k * KW + j) % 256);
        return d;
    endfunction

    // Garbage on the control inputs while busy; the DUT must ignore all of it.
    task automatic junk();
        start_i     = 1'($urandom);
        pkt_len_i   = 16'($urandom);
        pkt_cnt_i   = 16'($urandom);
        gap_i       = 8'($urandom);
        cs_i        = 16'($urandom);
        cancel_at_i = 16'($urandom);
    endtask

    // Run one burst from IDLE and check every cycle until done has come and gone.
    // delay < 0 picks a random grant delay per packet.
    task automatic run_burst(input int len, input int cnt, input int gap,
                             input int cs, input int cancel_at, input int delay);
        int b, nb, d, blen, sent_m, canc_m;
        bit canc;
        sent_m = 0;
        canc_m = 0;
        b    = (len + KW - 1) / KW;
        canc = CANC_EN && (cancel_at < b);
        nb   = canc ? cancel_at : b;
        pkt_len_i = 16'(len); pkt_cnt_i = 16'(cnt); gap_i = 8'(gap);
        cs_i = 16'(cs); cancel_at_i = 16'(cancel_at);
        bus.app_ready_v_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int p = 0; p < cnt; p++) begin
            d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            for (int i = 0; i <= d; i++) begin
                chk("head_early", 64'(bus.app_early_v_o), 64'(1));
                chk("head_valid", 64'(bus.app_valid_o), 64'(0));
                if (i == 0) begin
                    chk("head_pkt_len", 64'(bus.app_pkt_len_o), 64'(len));
                    chk("head_cs", 64'(bus.app_cs_o), 64'(cs));
                    chk("head_busy", 64'(busy_o), 64'(1));
                    chk("head_sent", 64'(sent_cnt_o), 64'(sent_m));
                    chk("head_cancel_cnt", 64'(cancel_cnt_o), 64'(canc_m));
                end
                junk();
                bus.app_ready_v_i = (i == d);
                @(negedge clk);
            end
            for (int k = 0; k < nb; k++) begin
                blen = (k < b - 1 || len % KW == 0) ? KW : len % KW;
                chk("beat_early", 64'(bus.app_early_v_o), 64'(0));
                chk("beat_valid", 64'(bus.app_valid_o), 64'(1));
                chk("beat_cancel", 64'(bus.app_cancel_o), 64'(0));
                chk("beat_len", 64'(bus.app_len_o), 64'(blen));
                chk("beat_data", 64'(bus.app_data_o), 64'(exp_data(p, k, blen)));
                junk();
                bus.app_ready_v_i = 1'($urandom);
                @(negedge clk);
            end
            if (canc) begin
                chk("cancel_pulse", 64'(bus.app_cancel_o), 64'(1));
                chk("cancel_valid", 64'(bus.app_valid_o), 64'(0));
                canc_m++;
                junk();
                @(negedge clk);
            end else begin
                sent_m++;
            end
            if (p == cnt - 1) begin
                chk("done_pulse", 64'(done_o), 64'(1));
                chk("done_busy", 64'(busy_o), 64'(0));
                chk("done_sent", 64'(sent_cnt_o), 64'(sent_m));
                chk("done_cancel_cnt", 64'(cancel_cnt_o), 64'(canc_m));
                chk("done_early", 64'(bus.app_early_v_o), 64'(0));
                chk("done_valid", 64'(bus.app_valid_o), 64'(0));
                start_i = 1'b0;
                bus.app_ready_v_i = 1'b0;
                @(negedge clk);
                chk("done_single", 64'(done_o), 64'(0));
                chk("idle_busy", 64'(busy_o), 64'(0));
            end else begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_early", 64'(bus.app_early_v_o), 64'(0));
                    chk("gap_valid", 64'(bus.app_valid_o), 64'(0));
                    chk("gap_data", 64'(bus.app_data_o), 64'(0));
                    chk("gap_len", 64'(bus.app_len_o), 64'(0));
                    chk("gap_busy", 64'(busy_o), 64'(1));
                    chk("gap_done", 64'(done_o), 64'(0));
                    junk();
                    bus.app_ready_v_i = 1'($urandom);
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        bus.app_ready_v_i = 1'b0;
        #2;
        chk("rst_early", 64'(bus.app_early_v_o), 64'(0));
        chk("rst_valid", 64'(bus.app_valid_o), 64'(0));
        chk("rst_data", 64'(bus.app_data_o), 64'(0));
        chk("rst_len", 64'(bus.app_len_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_sent", 64'(sent_cnt_o), 64'(0));
        chk("rst_cancel_cnt", 64'(cancel_cnt_o), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero length, then zero count: start must be ignored.
        for (int z = 0; z < 2; z++) begin
            pkt_len_i = (z == 0) ? 16'd0 : 16'd5;
            pkt_cnt_i = (z == 0) ? 16'd3 : 16'd0;
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("zero_busy", 64'(busy_o), 64'(0));
                chk("zero_done", 64'(done_o), 64'(0));
                chk("zero_early", 64'(bus.app_early_v_o), 64'(0));
                @(negedge clk);
            end
        end

        run_burst(19, 1, 0, 16'hBEEF, 100, 0);   // 10 beats, last carries 1 byte
        run_burst(4, 1, 0, 16'h1234, 100, 5);    // grant 5 cycles late
        run_burst(4, 3, 2, 16'h5A5A, 100, 0);    // burst with 2-cycle gaps
        run_burst(19, 1, 0, 16'h0F0F, 10, 0);    // cancel_at == B: no cancel

        // Reset on beat 3 of 10, then restart from packet 0.
        pkt_len_i = 16'd19; pkt_cnt_i = 16'd1; gap_i = 8'd0; cs_i = 16'h7777;
        start_i = 1'b1;
        bus.app_ready_v_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("rr_head", 64'(bus.app_early_v_o), 64'(1));
        repeat (4) @(negedge clk);
        chk("rr_beat3_data", 64'(bus.app_data_o), 64'(exp_data(0, 3, 2)));
        #1 reset = 1'b1;
        #1;
        chk("rr_valid", 64'(bus.app_valid_o), 64'(0));
        chk("rr_early", 64'(bus.app_early_v_o), 64'(0));
        chk("rr_cancel", 64'(bus.app_cancel_o), 64'(0));
        chk("rr_data", 64'(bus.app_data_o), 64'(0));
        chk("rr_len", 64'(bus.app_len_o), 64'(0));
        chk("rr_busy", 64'(busy_o), 64'(0));
        chk("rr_pkt_len", 64'(bus.app_pkt_len_o), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        bus.app_ready_v_i = 1'b0;
        @(negedge clk);
        run_burst(19, 1, 0, 16'h2222, 100, -1);

        if (CANC_EN) run_burst(19, 2, 1, 16'hCAFE, 4, 0);

        for (int r = 0; r < 8; r++)
            run_burst(int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 25)), -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_app_pkt_gen.md
# eth_app_pkt_gen

Synthesizable, parametrised application-side packet generator for `eth_tx`. It performs the early-valid / ready-grant handshake, then streams deterministic payload beats with per-beat byte length. It generalises the single-packet bench stimulus to any `DATA_W`, multi-packet bursts, programmable inter-packet gaps and optional cancel injection. It sits between a test/control register block and `eth_tx` in loopback and bring-up builds.

## Interface
- `DATA_W`, 16, payload beat width in bits; multiple of 8, minimum 16.
- `KEEP_W`, `DATA_W/8`, bytes per beat.
- `LEN_W`, `$clog2(KEEP_W+1)`, width of the byte-count field.
- `PKT_LEN_W`, 16, packet length field width, in bytes.
- `UDP_CS_W`, 16, checksum width.
- `CNT_W`, 16, width of the packet count and the statistics counters.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  single-cycle pulse; latches the configuration inputs. Only honoured in IDLE.
- `pkt_len_i`  in  `PKT_LEN_W`  payload bytes per packet.
- `pkt_cnt_i`  in  `CNT_W`  number of packets in the burst.
- `gap_i`  in  8  idle cycles between packets.
- `cs_i`  in  `UDP_CS_W`  checksum value presented with every packet.
- `cancel_at_i`  in  `PKT_LEN_W`  beat index at which cancel is injected (only used with the macro).
- `app_early_v_o`  out  1  packet request.
- `app_ready_v_i`  in  1  grant from `eth_tx`.
- `app_valid_o`  out  1  payload beat valid.
- `app_data_o`  out  `DATA_W`  payload; byte 0 is in bits [7:0].
- `app_len_o`  out  `LEN_W`  valid bytes in the beat, counted from byte 0.
- `app_pkt_len_o`  out  `PKT_LEN_W`  latched `pkt_len_i`.
- `app_cs_o`  out  `UDP_CS_W`  latched `cs_i`.
- `app_cancel_o`  out  1  abort the current packet.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when the burst completes.
- `sent_cnt_o`  out  `CNT_W`  packets fully sent since the last `start_i`.
- `cancel_cnt_o`  out  `CNT_W`  packets cancelled since the last `start_i`.

## Operation
- States: IDLE, HEAD, DATA, GAP.
- IDLE
  - `start_i` with `pkt_len_i` != 0 and `pkt_cnt_i` != 0: latch the configuration, clear both counters and the packet index p, then go to HEAD.
  - If either length or count is 0, `start_i` is ignored: no state change and no `done_o`.
- `start_i` outside IDLE is ignored.
- HEAD
  - Drive `app_early_v_o`=1, with `app_pkt_len_o` and `app_cs_o` valid.
  - When `app_ready_v_i` is sampled at 1, go to DATA. Otherwise stay in HEAD indefinitely.
- DATA
  - Beats per packet: `B = ceil(pkt_len/KEEP_W)`, counted with a beat index k from 0 to B-1.
  - `app_valid_o`=1 on every cycle. There is no per-beat backpressure; the beats are contiguous.
  - `app_len_o` = `KEEP_W` for k < B-1.
  - On the last beat, `app_len_o` = `pkt_len mod KEEP_W`, or `KEEP_W` if that remainder is 0.
  - Payload byte j of beat k = `(p + k*KEEP_W + j) mod 256`. Bytes at or beyond `app_len_o` are driven 0.
- End of packet
  - After the last beat: increment `sent_cnt_o` and p.
  - If p has reached `pkt_cnt`: pulse `done_o` on the next cycle and go to IDLE.
  - Otherwise go to GAP if `gap` > 0, or straight to HEAD if `gap` = 0.
- GAP: counts `gap` cycles with all app outputs low, then goes to HEAD.
- Idle output values: when not in HEAD or DATA, `app_valid_o`, `app_early_v_o` and `app_cancel_o` are 0, and `app_data_o` and `app_len_o` are 0.
- Counters saturate at all-ones.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and the counters and p are 0. Reset takes effect immediately and asynchronously.
- Reset asserted mid-packet drops `app_valid_o` and `app_early_v_o` at once. No cancel is emitted.
- Handshake timing:
  - `start_i` at cycle 0: `app_early_v_o`=1 from cycle 1.
  - Grant sampled at cycle n: `app_early_v_o` falls and the first beat is driven in cycle n+1.
  - Grant in the first HEAD cycle gives zero extra wait.
- Done timing: last beat in cycle t, then `done_o` in cycle t+1. `busy_o` falls in the same cycle.
- Gap timing: last beat in cycle t, then `app_early_v_o` rises in cycle t+1+gap.
- `app_ready_v_i` is ignored outside HEAD.

## Configuration
- `PKT_GEN_CANCEL_EN` defined:
  - On beat k == `cancel_at` with k < B, drive `app_cancel_o`=1 and `app_valid_o`=0 for one cycle.
  - The packet ends there. Increment `cancel_cnt_o` and p; `sent_cnt_o` is not incremented.
  - Then take the normal GAP/HEAD/IDLE decision.
  - If `cancel_at` >= B, no cancel is injected.
- `PKT_GEN_CANCEL_EN` undefined:
  - `cancel_at_i` is unused, `app_cancel_o` is tied to 0 and `cancel_cnt_o` is tied to 0.

## Test plan
- Single packet, `DATA_W`=16, len 19, cnt 1, grant held high:
  - 10 beats, 9 with len 2 and the 10th with len 1.
  - Data bytes are 0x00..0x12; the last beat upper byte is 0.
  - `done_o` follows 1 cycle after the last beat; `sent_cnt_o`=1.
- Grant delayed 5 cycles after `app_early_v_o`: early_v stays high for exactly 6 cycles and the first beat comes on the cycle after the grant.
- Burst with cnt 3, len 4, gap 2:
  - Packets are separated by exactly 2 idle cycles.
  - Packet 2 byte 0 = 0x02.
  - `sent_cnt_o`=3 with a single `done_o`.
- Zero configuration, `start_i` with len 0:
  - `busy_o` stays 0 and there is no `done_o`.
  - `start_i` while busy has no effect.
- Reset asserted on beat 3 of 10: all outputs go to 0 immediately, and a new `start_i` after release restarts from p=0.
- With `PKT_GEN_CANCEL_EN`, len 19, cnt 2, `cancel_at` 4:
  - Each packet sends beats 0-3, then one cancel cycle.
  - `cancel_cnt_o`=2, `sent_cnt_o`=0.
